// File: rtl/banked_sram_pkg.sv
// Shared constants and helpers for the banked SRAM crossbar: bank-index width,
// bank-select encodings and the conflict-counter width.
package banked_sram_pkg;

  localparam int BANK_SEL_LOW  = 0;
  localparam int BANK_SEL_HIGH = 1;
  localparam int STAT_W        = 16;

  function automatic int bank_idx_w(input int nb);
    return $clog2(nb);
  endfunction

endpackage

// File: rtl/bsx_bank.sv
// One SRAM bank: request decode, round-robin arbiter, byte-masked write, read pipeline.
// The conflict counter exists only when BANKED_SRAM_STATS_EN is defined.
module bsx_bank
  import banked_sram_pkg::*;
#(
  parameter int NB       = 8,
  parameter int M        = 8,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int BANK_SEL = BANK_SEL_LOW,
  parameter int BANK_ID  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stat_clr,
  input  logic [M-1:0]          req_v,
  input  logic [M-1:0]          req_we,
  input  logic [M*DATA_W/8-1:0] req_be,
  input  logic [M*ADDR_W-1:0]   req_addr,
  input  logic [M*DATA_W-1:0]   req_wdata,
  output logic [M-1:0]          grant,
  output logic [M-1:0]          rsp_v,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [STAT_W-1:0]     stat_cnt
);

  localparam int BW    = bank_idx_w(NB);
  localparam int IAW   = ADDR_W - BW;
  localparam int DEPTH = 1 << IAW;
  localparam int BYTES = DATA_W / 8;
  localparam int PW    = (M > 1) ? $clog2(M) : 1;

  logic [M-1:0]     hit;
  logic [BW-1:0]    bank_of  [M];
  logic [IAW-1:0]   iaddr_of [M];

  // Grants are masked by rst_n so req_ready is low for the whole reset window.
  for (genvar gi = 0; gi < M; gi++) begin : g_dec
    logic [ADDR_W-1:0] a;
    assign a = req_addr[gi*ADDR_W +: ADDR_W];
    if (BANK_SEL == BANK_SEL_HIGH) begin : g_high
      assign bank_of[gi]  = a[ADDR_W-1 -: BW];
      assign iaddr_of[gi] = a[IAW-1:0];
    end else begin : g_low
      assign bank_of[gi]  = a[BW-1:0];
      assign iaddr_of[gi] = a[ADDR_W-1:BW];
    end
    assign hit[gi] = rst_n && req_v[gi] && (bank_of[gi] == BW'(BANK_ID));
  end

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic          found;

  // Scan from the priority pointer; the first requester found wins.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < M; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= M) idx = idx - M;
      if (!found && hit[idx]) begin
        found      = 1'b1;
        gidx       = PW'(idx);
        grant[idx] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(gidx) == M - 1) ? '0 : gidx + 1'b1;
  end

  logic              wr_en, rd_en;
  logic [IAW-1:0]    mem_addr;
  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  wbe;

  assign wr_en    = found && req_we[gidx];
  assign rd_en    = found && !req_we[gidx];
  assign mem_addr = iaddr_of[gidx];
  assign wdata    = req_wdata[gidx*DATA_W +: DATA_W];
  assign wbe      = req_be[gidx*BYTES +: BYTES];

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] dpipe_q  [RD_LAT];
  logic [M-1:0]      vld_q    [RD_LAT];
  logic [M-1:0]      vld_d    [RD_LAT];

  // Stage 0 is the SRAM output register; later stages only add latency.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++)
        if (wbe[b]) mem[mem_addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (rd_en) dpipe_q[0] <= mem[mem_addr];
    for (int k = 1; k < RD_LAT; k++) dpipe_q[k] <= dpipe_q[k-1];
  end

  always_comb begin
    vld_d[0] = rd_en ? grant : '0;
    for (int k = 1; k < RD_LAT; k++) vld_d[k] = vld_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int k = 0; k < RD_LAT; k++) vld_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < RD_LAT; k++) vld_q[k] <= vld_d[k];
    end
  end

  assign rsp_v    = vld_q[RD_LAT-1];
  assign rsp_data = dpipe_q[RD_LAT-1];

`ifdef BANKED_SRAM_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  // Two or more requesters means hit has more than one bit set.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr)
      stat_d = '0;
    else if (((hit & (hit - 1'b1)) != '0) && (stat_q != '1))
      stat_d = stat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: rtl/banked_sram_xbar.sv
// M request streams into NB independently arbitrated SRAM banks with RD_LAT read latency.
// Per-bank conflict counters are present only when BANKED_SRAM_STATS_EN is defined.
module banked_sram_xbar
  import banked_sram_pkg::*;
#(
  parameter int NB       = 8,
  parameter int M        = 8,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int BANK_SEL = BANK_SEL_LOW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [M-1:0]          req_v,
  input  logic [M-1:0]          req_we,
  input  logic [M*DATA_W/8-1:0] req_be,
  input  logic [M*ADDR_W-1:0]   req_addr,
  input  logic [M*DATA_W-1:0]   req_wdata,
  output logic [M-1:0]          req_ready,
  output logic [M-1:0]          rsp_v,
  output logic [M*DATA_W-1:0]   rsp_rdata,
  input  logic                  stat_clr,
  output logic [NB*STAT_W-1:0]  stat_conflict
);

  logic [M-1:0]      gnt_b   [NB];
  logic [M-1:0]      rsp_v_b [NB];
  logic [DATA_W-1:0] rdata_b [NB];
  logic [STAT_W-1:0] stat_b  [NB];

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    bsx_bank #(
      .NB       (NB),
      .M        (M),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RD_LAT   (RD_LAT),
      .BANK_SEL (BANK_SEL),
      .BANK_ID  (gi)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .stat_clr  (stat_clr),
      .req_v     (req_v),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .grant     (gnt_b[gi]),
      .rsp_v     (rsp_v_b[gi]),
      .rsp_data  (rdata_b[gi]),
      .stat_cnt  (stat_b[gi])
    );
    assign stat_conflict[gi*STAT_W +: STAT_W] = stat_b[gi];
  end

  // A stream is accepted by at most one bank per cycle, so OR-folding is exact.
  always_comb begin
    req_ready = '0;
    rsp_v     = '0;
    rsp_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      req_ready = req_ready | gnt_b[b];
      rsp_v     = rsp_v | rsp_v_b[b];
      for (int m = 0; m < M; m++)
        if (rsp_v_b[b][m])
          rsp_rdata[m*DATA_W +: DATA_W] = rsp_rdata[m*DATA_W +: DATA_W] | rdata_b[b];
    end
  end

endmodule
